bnn_layer2_argmax: RTL and testbench
====================================

# bnn_layer2_argmax

Second-layer classifier stage for the 8-8-4 BNN. It consumes the 8-bit layer-1 activation vector, evaluates the 4 output neurons one per cycle using a single shared XNOR-popcount datapath, and applies a threshold to each neuron. It then emits the 4 output bits plus the argmax class index through a valid/ready handshake. Layer-2 weights reset to the team defaults and can be reloaded through a serial nibble port.

## Interface
Parameters:
- NUM_OUT, 4: number of layer-2 neurons; fixed at 4 in this revision.
- THRESH, 6: activation threshold. A neuron fires when its sum is >= THRESH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable. When low, all registers hold.
- act_in  in  8  layer-1 activations; bit i is neuron i.
- act_valid  in  1  act_in is valid.
- act_ready  out  1  high only in IDLE.
- wl_en  in  1  weight-load strobe; one nibble per cycle.
- wl_nibble  in  4  weight nibble; low nibble is sent first.
- out_bits  out  4  neuron outputs; bit k is neuron k.
- class_idx  out  2  index of the largest sum; a tie goes to the lowest index.
- max_sum  out  4  sum of the winning neuron, 0..8.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts the result.

## Operation
- State machine states: IDLE, COMPUTE, DONE.
- Reset (rst_n low at an edge):
  - state=IDLE, out_bits=0, class_idx=0, max_sum=0, out_valid=0.
  - Load pointer=0, nibble phase=0, neuron counter=0.
  - Weights load to defaults: w0=8'b11111001, w1=8'b01100010, w2=8'b11110111, w3=8'b00001111.
  - Reset taken mid-COMPUTE or in DONE aborts the operation; no result is emitted.
- IDLE:
  - act_valid && ena at an edge captures act_in into act_reg.
  - The same edge clears the running max and out_bits, sets cnt=0, and moves to COMPUTE.
- COMPUTE:
  - Each cycle evaluates neuron cnt: sum = popcount(act_reg XNOR w[cnt]), 4-bit, range 0..8.
  - out_bits[cnt] is set to (sum >= THRESH).
  - If sum > running max, or cnt==0, the running max and class_idx are updated. Strict greater-than keeps the lowest index on a tie.
  - After cnt==3 the state moves to DONE, and cnt wraps to 0.
- DONE:
  - out_valid=1 and the outputs are stable.
  - out_ready at an edge clears out_valid and returns to IDLE.
  - act_ready stays 0 in DONE, so a new input is accepted only on a later cycle.
- Weight load:
  - Accepted only in IDLE with ena. wl_en in COMPUTE or DONE is ignored, and the nibble phase and pointer do not advance.
  - Phase 0 buffers the nibble.
  - Phase 1 writes w[ptr] = {wl_nibble, buffered nibble}, increments ptr, and wraps it 3->0.
- Simultaneous wl_en and act_valid in IDLE: both take effect at the same edge. COMPUTE starts the next cycle and uses the just-written weight.
- ena low freezes everything, including the handshake. Outputs hold their values.

## Timing
- If input is accepted at edge T:
  - Neuron k is registered at edge T+1+k.
  - The state is DONE and out_valid=1 after edge T+4.
- Minimum throughput is one result per 6 cycles: 1 cycle IDLE, 4 cycles COMPUTE, at least 1 cycle DONE.
- out_bits, class_idx and max_sum are registered outputs. They are guaranteed valid only while out_valid=1.
- act_ready and out_valid are decoded combinationally from the state register.

## Structure
- Package bnn_pkg holds:
  - The state enum (IDLE/COMPUTE/DONE).
  - NUM_OUT and THRESH defaults.
  - The default layer-2 weight constants.
  - The 4-bit sum type.
- Sub-module bnn_popcount8: combinational 8-bit XNOR-popcount, inputs a[7:0] and w[7:0], output sum[3:0]. It is instantiated once and shared across the 4 neurons by muxing w[cnt].

## Test plan
- Reset defaults, act_in=8'hFF: sums are 6,3,7,4 -> out_bits=4'b0101, class_idx=2, max_sum=7. out_valid rises 4 edges after acceptance.
- Reset defaults, act_in=8'h00: sums are 2,5,1,4 -> out_bits=4'b0000, class_idx=1, max_sum=5.
- Load all four weights as 8'h00 (nibbles 0,0 x4), then act_in=8'h00: all sums are 8 -> out_bits=4'b1111, class_idx=0 (tie to lowest index), max_sum=8.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, outputs stay stable, act_ready=0. Pulsing act_valid in that window is ignored.
- wl_en during COMPUTE with nibble 4'hF -> weights unchanged; a subsequent act_in=8'hFF still gives out_bits=4'b0101.
- rst_n low for one edge at cnt==2 -> IDLE, out_valid=0, weights back to defaults, no result emitted; the next input completes normally.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the 8-8-4 BNN layer-2 classifier stage.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    typedef logic [3:0] sum_t;

    localparam int BNN_NUM_OUT = 4;
    localparam int BNN_THRESH  = 6;

    localparam logic [7:0] W0_DEFAULT = 8'b11111001;
    localparam logic [7:0] W1_DEFAULT = 8'b01100010;
    localparam logic [7:0] W2_DEFAULT = 8'b11110111;
    localparam logic [7:0] W3_DEFAULT = 8'b00001111;

endpackage

// File: rtl/bnn_popcount8.sv
// Combinational XNOR-popcount of an 8-bit activation vector against one weight row.
module bnn_popcount8
    import bnn_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] w,
    output sum_t       sum
);

    logic [7:0] match;

    always_comb begin
        match = ~(a ^ w);
        sum   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum = sum + {3'b000, match[i]};
        end
    end

endmodule

// File: rtl/bnn_layer2_argmax.sv
// Layer-2 stage: four neurons evaluated sequentially on one shared popcount,
// thresholded, with argmax (ties to lowest index) and a serial nibble weight loader.
module bnn_layer2_argmax
    import bnn_pkg::*;
#(
    parameter int NUM_OUT = BNN_NUM_OUT,
    parameter int THRESH  = BNN_THRESH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [7:0]   act_in,
    input  logic         act_valid,
    output logic         act_ready,
    input  logic         wl_en,
    input  logic [3:0]   wl_nibble,
    output logic [3:0]   out_bits,
    output logic [1:0]   class_idx,
    output sum_t         max_sum,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam sum_t       THRESH_S = sum_t'(THRESH);
    localparam logic [1:0] CNT_LAST = 2'(NUM_OUT - 1);

    state_t      state;
    logic [7:0]  act_reg;
    logic [1:0]  cnt;
    logic [7:0]  w [NUM_OUT];
    logic [1:0]  ptr;
    logic        phase;
    logic [3:0]  nib_buf;
    logic [7:0]  w_sel;
    sum_t        sum;

    assign act_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign w_sel     = w[cnt];

    bnn_popcount8 u_popcount (
        .a   (act_reg),
        .w   (w_sel),
        .sum (sum)
    );

    // max_sum doubles as the running maximum during COMPUTE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            act_reg   <= '0;
            cnt       <= '0;
            out_bits  <= '0;
            class_idx <= '0;
            max_sum   <= '0;
            ptr       <= '0;
            phase     <= 1'b0;
            nib_buf   <= '0;
            w[0]      <= W0_DEFAULT;
            w[1]      <= W1_DEFAULT;
            w[2]      <= W2_DEFAULT;
            w[3]      <= W3_DEFAULT;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (wl_en) begin
                        if (!phase) begin
                            nib_buf <= wl_nibble;
                            phase   <= 1'b1;
                        end else begin
                            w[ptr] <= {wl_nibble, nib_buf};
                            ptr    <= ptr + 2'd1;
                            phase  <= 1'b0;
                        end
                    end
                    if (act_valid) begin
                        act_reg  <= act_in;
                        max_sum  <= '0;
                        out_bits <= '0;
                        cnt      <= '0;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    out_bits[cnt] <= (sum >= THRESH_S);
                    // Strict compare keeps the lowest index on ties.
                    if (sum > max_sum || cnt == 2'd0) begin
                        max_sum   <= sum;
                        class_idx <= cnt;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_layer2_argmax.sv
// Directed-vector bench for bnn_layer2_argmax with hand-computed sums.
module tb_bnn_layer2_argmax;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] act_in;
    logic       act_valid;
    logic       act_ready;
    logic       wl_en;
    logic [3:0] wl_nibble;
    logic [3:0] out_bits;
    logic [1:0] class_idx;
    logic [3:0] max_sum;
    logic       out_valid;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    bnn_layer2_argmax #(.NUM_OUT(4), .THRESH(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .act_in    (act_in),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .wl_en     (wl_en),
        .wl_nibble (wl_nibble),
        .out_bits  (out_bits),
        .class_idx (class_idx),
        .max_sum   (max_sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_vec(input logic [7:0] a);
        @(negedge clk);
        act_in    = a;
        act_valid = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input int bits, input int idx, input int mx);
        check_eq({tag, "_valid"}, int'(out_valid), 1);
        check_eq({tag, "_bits"},  int'(out_bits), bits);
        check_eq({tag, "_idx"},   int'(class_idx), idx);
        check_eq({tag, "_max"},   int'(max_sum), mx);
        check_eq({tag, "_rdy"},   int'(act_ready), 0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_rel_valid"}, int'(out_valid), 0);
        check_eq({tag, "_rel_rdy"},   int'(act_ready), 1);
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a,
                           input int bits, input int idx, input int mx);
        start_vec(a);
        wait_done(tag, 4);
        check_result(tag, bits, idx, mx);
    endtask

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        wl_en     = 1'b1;
        wl_nibble = b[3:0];
        @(negedge clk);
        wl_nibble = b[7:4];
        @(negedge clk);
        wl_en     = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; ena = 1'b1; act_in = '0; act_valid = 1'b0;
        wl_en = 1'b0; wl_nibble = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_rdy",   int'(act_ready), 1);
        check_eq("rst_bits",  int'(out_bits), 0);
        check_eq("rst_idx",   int'(class_idx), 0);
        check_eq("rst_max",   int'(max_sum), 0);

        // Default weights: sums 6,3,7,4 and 2,5,1,4.
        run_vec("ff", 8'hFF, 4'b0101, 2, 7);
        release_out("ff");
        run_vec("zz", 8'h00, 4'b0000, 1, 5);
        release_out("zz");

        // Backpressure with act_valid pulses that must be ignored.
        run_vec("bp", 8'hFF, 4'b0101, 2, 7);
        for (int i = 0; i < 10; i++) begin
            act_in    = 8'h00;
            act_valid = (i % 2 == 0);
            @(negedge clk);
            check_eq("bp_valid", int'(out_valid), 1);
            check_eq("bp_bits",  int'(out_bits), 4'b0101);
            check_eq("bp_idx",   int'(class_idx), 2);
            check_eq("bp_max",   int'(max_sum), 7);
            check_eq("bp_rdy",   int'(act_ready), 0);
        end
        act_valid = 1'b0;

        // ena low freezes the handshake.
        ena = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("ena_hold_valid", int'(out_valid), 1);
        ena = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("ena_rel_valid", int'(out_valid), 0);
        check_eq("ena_rel_rdy",   int'(act_ready), 1);

        // wl_en during COMPUTE is ignored.
        start_vec(8'hFF);
        wl_en = 1'b1; wl_nibble = 4'hF;
        repeat (2) @(negedge clk);
        wl_en = 1'b0;
        wait_done("wlc", 2);
        check_result("wlc", 4'b0101, 2, 7);
        release_out("wlc");
        run_vec("wlc2", 8'hFF, 4'b0101, 2, 7);
        release_out("wlc2");

        // All weights zero: act 00 gives sums of 8, tie resolves to index 0.
        repeat (4) load_byte(8'h00);
        run_vec("w0", 8'h00, 4'b1111, 0, 8);
        release_out("w0");

        // Reset while cnt==2 aborts and restores default weights.
        start_vec(8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_valid", int'(out_valid), 0);
        check_eq("mid_rdy",   int'(act_ready), 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_eq("mid_no_result", seen, 0);
        run_vec("mid_ff", 8'hFF, 4'b0101, 2, 7);
        release_out("mid_ff");

        // Second nibble of w0=00 coincides with acceptance; sums 8,5,1,4.
        @(negedge clk);
        wl_en = 1'b1; wl_nibble = 4'h0;
        @(negedge clk);
        act_in = 8'h00; act_valid = 1'b1;
        @(negedge clk);
        wl_en = 1'b0; act_valid = 1'b0;
        wait_done("sim", 4);
        check_result("sim", 4'b0001, 0, 8);
        release_out("sim");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
